problem5_mux4_reg: RTL and testbench
====================================

// Module: problem5_mux4_reg
// PURPOSE
//   Registered 4:1 data selector. Picks one of four DATA_W-bit inputs with a
//   2-bit select and presents it on a registered output one clock later.
//   Sits on a datapath where the source is chosen per cycle by control logic
//   and a clean, glitch-free registered output is required downstream.
// PARAMETERS
//   DATA_W     16    width of each data input and of o_data
//   RESET_VAL  0     value loaded into o_data while reset is asserted (DATA_W bits)
// PORTS
//   i_clk      in   1       system clock; all state updates on rising edge
//   i_rst_n    in   1       synchronous reset, active-low
//   i_data_0   in   DATA_W  source 0, selected when i_ctrl == 2'd0
//   i_data_1   in   DATA_W  source 1, selected when i_ctrl == 2'd1
//   i_data_2   in   DATA_W  source 2, selected when i_ctrl == 2'd2
//   i_data_3   in   DATA_W  source 3, selected when i_ctrl == 2'd3
//   i_ctrl     in   2       source select
//   o_data     out  DATA_W  registered selected data
// BEHAVIOUR
//   - Single clock domain (i_clk). Reset is synchronous and active-low: it is
//     sampled only on the rising edge of i_clk; no asynchronous path.
//   - Rising edge with i_rst_n == 0: o_data <= RESET_VAL. Select and data
//     inputs are ignored on that edge.
//   - Rising edge with i_rst_n == 1: o_data <= i_data_[i_ctrl]. i_ctrl and the
//     data inputs are sampled on the same edge.
//   - Latency: exactly 1 cycle from sampled select/data to o_data. The block
//     has no enable and no hold: o_data is updated on every non-reset edge.
//   - All four i_ctrl codes are legal. If i_ctrl contains X/Z in simulation,
//     o_data is X. Synthesis must not infer a latch.
//   - A change on a selected input takes effect at the next rising edge, with
//     or without a change on i_ctrl. A change on an unselected input has no
//     effect.
//   - Between edges o_data is stable. Input changes never propagate
//     combinationally to o_data.
//   - Power-up value before the first reset edge is undefined. Consumers must
//     apply at least one reset edge.
//   - Reset asserted mid-stream forces RESET_VAL on the next edge. The first
//     edge after deassertion loads the selected input; no extra delay cycle.
//   - Data is passed bit-for-bit with no arithmetic, sign handling or
//     truncation. All widths equal DATA_W.
// TESTING
//   Clock period is 2 time units. Stimulus changes on falling edges. Use
//   d0=0x0000, d1=0x000F, d2=0x0005, d3=0x0008 unless noted.
//   1. Hold i_rst_n=0 for 2 edges, any i_ctrl -> o_data == 0x0000 (RESET_VAL).
//   2. Release reset, sweep i_ctrl 0,1,2,3 on successive cycles -> o_data
//      reads 0x0000, 0x000F, 0x0005, 0x0008, each one edge after its select.
//   3. Set d0=0x000B together with i_ctrl=0 -> the next edge gives
//      o_data == 0x000B.
//   4. i_ctrl=2 held, change d1 to 0xFFFF -> o_data remains 0x0005. Then
//      change d2 to 0xA5A5 -> o_data == 0xA5A5 after the next edge.
//   5. While o_data == 0x0008, drive i_rst_n=0 for one edge -> o_data ==
//      0x0000. Release with i_ctrl=1 -> 0x000F on the following edge.
//   6. Between edges, toggle i_ctrl and all data inputs -> o_data does not
//      change until the next rising edge.

Source files
------------

// File: rtl/problem5_mux4_reg.sv
// Registered 4:1 data selector.
// Picks one of four DATA_W-bit sources with a 2-bit select and presents the
// choice on o_data one rising edge later. The output comes straight from a
// flop, so downstream logic only sees changes at clock edges.
// Reset is synchronous and active-low. It loads RESET_VAL and ignores the
// select and data inputs on that edge.
// Sources, select, and output carry no handshake. Every non-reset edge
// captures the currently selected source unconditionally: there is no
// enable and no hold.

module problem5_mux4_reg #(
  parameter int                DATA_W    = 16,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_data_0,
  input  logic [DATA_W-1:0] i_data_1,
  input  logic [DATA_W-1:0] i_data_2,
  input  logic [DATA_W-1:0] i_data_3,
  input  logic [1:0]        i_ctrl,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] sel_data;

  // Select the source. All four codes are decoded explicitly.
  // The default arm is reached only when i_ctrl is X/Z in simulation, and
  // it propagates X in that case. Every path assigns sel_data, so no latch
  // can be inferred.
  always_comb begin
    sel_data = '0;
    case (i_ctrl)
      2'd0:    sel_data = i_data_0;
      2'd1:    sel_data = i_data_1;
      2'd2:    sel_data = i_data_2;
      2'd3:    sel_data = i_data_3;
      default: sel_data = 'x;
    endcase
  end

  // Output register: reset wins; otherwise capture the selection every edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_data <= RESET_VAL;
    end else begin
      o_data <= sel_data;
    end
  end

endmodule

// File: tb/tb_problem5_mux4_reg.sv
// Bench for the registered 4:1 selector.
// Stimulus changes on falling edges. Each expected output is pushed to
// exp_q when its stimulus is applied. The entry is popped and compared on
// the falling edge after the rising edge that should have produced it.
`timescale 1ns/100ps

module tb_problem5_mux4_reg;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] d0, d1, d2, d3;
  logic [1:0]   ctrl;
  logic [W-1:0] o_data;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;
  logic [W-1:0] held;
  int           n_compared;
  int           n_failed;

  problem5_mux4_reg #(.DATA_W(W), .RESET_VAL(16'h0000)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_data_0(d0),
    .i_data_1(d1),
    .i_data_2(d2),
    .i_data_3(d3),
    .i_ctrl  (ctrl),
    .o_data  (o_data)
  );

  // Clock / reset block: period 2, first rising edge at t=1.
  initial clk = 1'b0;
  always #1 clk = ~clk;

  initial begin
    rst_n = 1'b0;
    ctrl  = 2'd0;
    d0 = 16'h0000; d1 = 16'h000F; d2 = 16'h0005; d3 = 16'h0008;
  end

  // Advance through one rising edge, and stop on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference selection taken from the bench's own copies of the inputs.
  function automatic logic [W-1:0] ref_sel(input logic [1:0] c);
    logic [W-1:0] r;
    r = 16'h0000;
    if (c == 2'd0) r = d0;
    if (c == 2'd1) r = d1;
    if (c == 2'd2) r = d2;
    if (c == 2'd3) r = d3;
    return r;
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      rst_n = 1'b0;
      ctrl  = 2'($urandom_range(0, 3));
      exp_q.push_back(16'h0000);
      tick();
      if (exp_q.size() == 0) begin
        n_failed++;
        $display("FAIL reset: scoreboard empty, o_data=%h", o_data);
      end else begin
        exp_v = exp_q.pop_front();
        n_compared++;
        if (o_data !== exp_v) begin
          n_failed++;
          $display("FAIL reset[%0d]: got %h expected %h", i, o_data, exp_v);
        end
      end
    end
  endtask

  task automatic test_sweep();
    logic [W-1:0] tbl [4];
    tbl[0] = 16'h0000; tbl[1] = 16'h000F; tbl[2] = 16'h0005; tbl[3] = 16'h0008;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ctrl = 2'(i);
      exp_q.push_back(tbl[i]);
      tick();
      exp_v = exp_q.pop_front();
      n_compared++;
      if (o_data !== exp_v) begin
        n_failed++;
        $display("FAIL sweep ctrl=%0d: got %h expected %h", i, o_data, exp_v);
      end
    end
  endtask

  task automatic test_data_change();
    d0   = 16'h000B;
    ctrl = 2'd0;
    exp_q.push_back(16'h000B);
    tick();
    exp_v = exp_q.pop_front();
    n_compared++;
    if (o_data !== exp_v) begin
      n_failed++;
      $display("FAIL data_change: got %h expected %h", o_data, exp_v);
    end
  endtask

  task automatic test_unselected();
    ctrl = 2'd2;
    d1   = 16'hFFFF;
    exp_q.push_back(16'h0005);
    tick();
    exp_v = exp_q.pop_front();
    n_compared++;
    if (o_data !== exp_v) begin
      n_failed++;
      $display("FAIL unselected_change: got %h expected %h", o_data, exp_v);
    end
    d2 = 16'hA5A5;
    exp_q.push_back(16'hA5A5);
    tick();
    exp_v = exp_q.pop_front();
    n_compared++;
    if (o_data !== exp_v) begin
      n_failed++;
      $display("FAIL selected_change: got %h expected %h", o_data, exp_v);
    end
  endtask

  task automatic test_reset_mid();
    d1   = 16'h000F;
    ctrl = 2'd3;
    exp_q.push_back(16'h0008);
    tick();
    exp_v = exp_q.pop_front();
    n_compared++;
    if (o_data !== exp_v) begin
      n_failed++;
      $display("FAIL mid_pre: got %h expected %h", o_data, exp_v);
    end
    rst_n = 1'b0;
    exp_q.push_back(16'h0000);
    tick();
    exp_v = exp_q.pop_front();
    n_compared++;
    if (o_data !== exp_v) begin
      n_failed++;
      $display("FAIL mid_reset: got %h expected %h", o_data, exp_v);
    end
    rst_n = 1'b1;
    ctrl  = 2'd1;
    exp_q.push_back(16'h000F);
    tick();
    exp_v = exp_q.pop_front();
    n_compared++;
    if (o_data !== exp_v) begin
      n_failed++;
      $display("FAIL mid_release: got %h expected %h", o_data, exp_v);
    end
  endtask

  task automatic test_between_edges();
    for (int r = 0; r < 3; r++) begin
      held = o_data;
      for (int k = 0; k < 4; k++) begin
        ctrl = 2'($urandom_range(0, 3));
        d0 = 16'($urandom); d1 = 16'($urandom);
        d2 = 16'($urandom); d3 = 16'($urandom);
        #0.2;
        n_compared++;
        if (o_data !== held) begin
          n_failed++;
          $display("FAIL between_edges r=%0d k=%0d: got %h expected %h", r, k, o_data, held);
        end
      end
      exp_q.push_back(ref_sel(ctrl));
      tick();
      exp_v = exp_q.pop_front();
      n_compared++;
      if (o_data !== exp_v) begin
        n_failed++;
        $display("FAIL between_edges_capture r=%0d: got %h expected %h", r, o_data, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      rst_n = ($urandom_range(0, 9) != 0);
      ctrl  = 2'($urandom_range(0, 3));
      d0 = 16'($urandom); d1 = 16'($urandom);
      d2 = 16'($urandom); d3 = 16'($urandom);
      exp_q.push_back(rst_n ? ref_sel(ctrl) : 16'h0000);
      tick();
      exp_v = exp_q.pop_front();
      n_compared++;
      if (o_data !== exp_v) begin
        n_failed++;
        $display("FAIL back_to_back[%0d] rst_n=%0d ctrl=%0d: got %h expected %h",
                 i, rst_n, ctrl, o_data, exp_v);
      end
    end
  endtask

  initial begin
    n_compared = 0;
    n_failed   = 0;
    @(negedge clk);
    test_reset();
    test_sweep();
    test_data_change();
    test_unselected();
    test_reset_mid();
    test_between_edges();
    test_back_to_back();
    n_compared++;
    if (exp_q.size() != 0) begin
      n_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
